// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing a single-port SRAM macro; registered chip-select/write-enable/address/data.
// Define SRAM_ARB_ROUND_ROBIN_EN for a round-robin pointer; otherwise port 0 has fixed priority.
module sram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [1:0]          gnt_q, gnt_nxt;
  logic [1:0]          rvalid_q, rvalid_nxt;
  logic                csb_nxt, we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                any_req, win, arb;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign any_req   = p0_req | p1_req;
  assign sel_we    = win ? p1_we    : p0_we;
  assign sel_addr  = win ? p1_addr  : p0_addr;
  assign sel_wdata = win ? p1_wdata : p0_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic ptr;

  // Pointer only decides ties; a lone requester wins outright.
  assign win = (p0_req & p1_req) ? ptr : ~p0_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= 1'b0;
    else if (arb) ptr <= ~win;
  end
`else
  assign win = ~p0_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    arb        = 1'b0;
    csb_nxt    = 1'b1;
    we_nxt     = 1'b1;
    addr_nxt   = addr;
    wdata_nxt  = sram_data_in;
    gnt_nxt    = 2'b00;
    rvalid_nxt = 2'b00;
    case (state)
      IDLE: begin
        if (any_req) arb = 1'b1;
      end
      ACCESS: begin
        // we_n still holds the current access type while in ACCESS.
        if (we_n) begin
          state_nxt  = RESP;
          rvalid_nxt = gnt_q;
        end else begin
          state_nxt  = IDLE;
        end
      end
      RESP: begin
        if (any_req) arb = 1'b1;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (arb) begin
      state_nxt = ACCESS;
      csb_nxt   = 1'b0;
      we_nxt    = ~sel_we;
      addr_nxt  = sel_addr;
      wdata_nxt = sel_wdata;
      gnt_nxt   = win ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csb_n        <= 1'b1;
      we_n         <= 1'b1;
      addr         <= '0;
      sram_data_in <= '0;
      gnt_q        <= 2'b00;
      rvalid_q     <= 2'b00;
    end else begin
      csb_n        <= csb_nxt;
      we_n         <= we_nxt;
      addr         <= addr_nxt;
      sram_data_in <= wdata_nxt;
      gnt_q        <= gnt_nxt;
      rvalid_q     <= rvalid_nxt;
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata  = sram_data_out;
  assign p1_rdata  = sram_data_out;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: SRAM model plus a queue of expected grant/rvalid events.
module tb_sram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          csb_n, we_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] sram_data_in;
  logic [DW-1:0] sram_data_out = '0;

  logic [DW-1:0] mem [32];
  bit            written [32];

  typedef struct {
    bit            is_rv;
    logic [1:0]    ports;
    int            cyc;
    logic          we_n;
    logic [AW-1:0] addr;
    bit            chk_data;
    logic [DW-1:0] data;
  } ev_t;

  ev_t q[$];
  int  ncmp = 0;
  int  nfail = 0;
  int  cyc = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .csb_n(csb_n), .we_n(we_n), .addr(addr), .sram_data_in(sram_data_in),
    .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return 32'hA5C30000 + 32'(a) * 32'h00000111;
  endfunction

  // Synchronous single-port SRAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (csb_n === 1'b0) begin
      if (we_n === 1'b0) begin
        mem[addr]     <= sram_data_in;
        written[addr] <= 1'b1;
      end else begin
        sram_data_out <= written[addr] ? mem[addr] : pre(addr);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic match(input bit is_rv, input logic [1:0] ports);
    ev_t e;
    if (q.size() == 0) begin
      check(is_rv ? "unexpected_rvalid" : "unexpected_gnt", 64'(ports), 64'd0);
      return;
    end
    e = q.pop_front();
    check("event_kind", 64'(is_rv), 64'(e.is_rv));
    check("event_port", 64'(ports), 64'(e.ports));
    check("event_cycle", 64'(cyc), 64'(e.cyc));
    if (!is_rv) begin
      check("gnt_csb_n", 64'(csb_n), 64'd0);
      check("gnt_we_n", 64'(we_n), 64'(e.we_n));
      check("gnt_addr", 64'(addr), 64'(e.addr));
      if (e.chk_data) check("gnt_data_in", 64'(sram_data_in), 64'(e.data));
    end else begin
      check("rdata", 64'(e.ports[1] ? p1_rdata : p0_rdata), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (p0_gnt === 1'b1 || p1_gnt === 1'b1)       match(1'b0, {p1_gnt, p0_gnt});
    if (p0_rvalid === 1'b1 || p1_rvalid === 1'b1) match(1'b1, {p1_rvalid, p0_rvalid});
  end

  task automatic exp_gnt(input int port, input int c, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.is_rv = 1'b0; e.ports = (port != 0) ? 2'b10 : 2'b01; e.cyc = c;
    e.we_n = ~we; e.addr = a; e.chk_data = we; e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_rv(input int port, input int c, input logic [DW-1:0] d);
    ev_t e;
    e.is_rv = 1'b1; e.ports = (port != 0) ? 2'b10 : 2'b01; e.cyc = c;
    e.we_n = 1'b1; e.addr = '0; e.chk_data = 1'b1; e.data = d;
    q.push_back(e);
  endtask

  task automatic drive0(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drive1(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    int c;
    int port;

    // Reset held with both ports requesting
    drive0(1'b1, 1'b0, 5'd3, '0);
    drive1(1'b1, 1'b1, 5'd4, 32'h11111111);
    repeat (3) @(negedge clk);
    check("rst_csb_n", 64'(csb_n), 64'd1);
    check("rst_we_n", 64'(we_n), 64'd1);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data_in", 64'(sram_data_in), 64'd0);
    check("rst_gnt", 64'({p1_gnt, p0_gnt}), 64'd0);
    check("rst_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'd0);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_csb_n", 64'(csb_n), 64'd1);
    check("idle_gnt", 64'({p1_gnt, p0_gnt}), 64'd0);

    // Port 0 write then read of address 5
    c = cyc;
    drive0(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    exp_gnt(0, c + 1, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk); drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    c = cyc;
    drive0(1'b1, 1'b0, 5'd5, '0);
    exp_gnt(0, c + 1, 1'b0, 5'd5, '0);
    exp_rv(0, c + 2, 32'hDEADBEEF);
    @(negedge clk); drive0(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Lone port-1 read: granted whatever the pointer says
    c = cyc;
    drive1(1'b1, 1'b0, 5'd2, '0);
    exp_gnt(1, c + 1, 1'b0, 5'd2, '0);
    exp_rv(1, c + 2, pre(5'd2));
    @(negedge clk); drive1(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Contention: both ports read continuously
    c = cyc;
    drive0(1'b1, 1'b0, 5'd1, '0);
    drive1(1'b1, 1'b0, 5'd2, '0);
    for (int k = 0; k < 4; k++) begin
      port = RR ? (k % 2) : 0;
      exp_gnt(port, c + 1 + 2 * k, 1'b0, (port != 0) ? 5'd2 : 5'd1, '0);
      exp_rv(port, c + 2 + 2 * k, pre((port != 0) ? 5'd2 : 5'd1));
    end
    repeat (8) @(negedge clk);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Read-to-write turnaround: p1 write waiting while p0 read is in RESP
    c = cyc;
    drive0(1'b1, 1'b0, 5'd3, '0);
    exp_gnt(0, c + 1, 1'b0, 5'd3, '0);
    exp_rv(0, c + 2, pre(5'd3));
    @(negedge clk);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b1, 5'd7, 32'h12345678);
    exp_gnt(1, c + 3, 1'b1, 5'd7, 32'h12345678);
    repeat (2) @(negedge clk);
    drive1(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    c = cyc;
    drive1(1'b1, 1'b0, 5'd7, '0);
    exp_gnt(1, c + 1, 1'b0, 5'd7, '0);
    exp_rv(1, c + 2, 32'h12345678);
    @(negedge clk); drive1(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset pulse during the ACCESS cycle of a p1 read: no rvalid may follow
    c = cyc;
    drive1(1'b1, 1'b0, 5'd4, '0);
    exp_gnt(1, c + 1, 1'b0, 5'd4, '0);
    @(negedge clk);
    drive1(1'b0, 1'b0, '0, '0);
    check("midrd_csb_active", 64'(csb_n), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midrd_csb_n", 64'(csb_n), 64'd1);
    check("midrd_gnt", 64'(p1_gnt), 64'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrd_rvalid", 64'(p1_rvalid), 64'd0);

    // Leave the pointer on port 1, then reset while idle
    c = cyc;
    drive0(1'b1, 1'b1, 5'd10, 32'h0BADF00D);
    exp_gnt(0, c + 1, 1'b1, 5'd10, 32'h0BADF00D);
    @(negedge clk); drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);

    // Tie after reset: port 0 must win first
    c = cyc;
    drive0(1'b1, 1'b0, 5'd1, '0);
    drive1(1'b1, 1'b0, 5'd2, '0);
    exp_gnt(0, c + 1, 1'b0, 5'd1, '0);
    exp_rv(0, c + 2, pre(5'd1));
    exp_gnt(1, c + 3, 1'b0, 5'd2, '0);
    exp_rv(1, c + 4, pre(5'd2));
    @(negedge clk); drive0(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk); drive1(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    // Withdrawn p1 request: raised during p0 ACCESS, dropped before arbitration
    c = cyc;
    drive0(1'b1, 1'b1, 5'd9, 32'hCAFEF00D);
    exp_gnt(0, c + 1, 1'b1, 5'd9, 32'hCAFEF00D);
    @(negedge clk);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 5'd6, '0);
    @(negedge clk);
    drive1(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("wd_csb_n", 64'(csb_n), 64'd1);
    check("wd_gnt", 64'(p1_gnt), 64'd0);
    repeat (2) @(negedge clk);
    check("wd_idle_csb_n", 64'(csb_n), 64'd1);

    repeat (2) @(negedge clk);
    check("events_pending", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
